bus_arbiter: RTL



---
 rtl/common.sv | 34 +++
 rtl/rr_pick2.sv | 20 ++
 rtl/bus_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/common.sv
// rtl/common.sv - shared coherence-bus op types and decode helper
package common;

  typedef logic [2:0] bus_op_t;

  typedef enum logic [2:0] {
    OP_NONE    = 3'd0,
    OP_RD_MISS = 3'd1,
    OP_WR_MISS = 3'd2,
    OP_INV     = 3'd3,
    OP_UWE     = 3'd4,
    OP_URE     = 3'd5
  } bus_arb_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // Encodings 6 and 7 are reserved and fold to OP_NONE.
  function automatic bus_arb_op_t op_decode(input bus_op_t raw);
    bus_arb_op_t op;
    case (raw)
      3'd1:    op = OP_RD_MISS;
      3'd2:    op = OP_WR_MISS;
      3'd3:    op = OP_INV;
      3'd4:    op = OP_UWE;
      3'd5:    op = OP_URE;
      default: op = OP_NONE;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - combinational two-way round-robin pick with per-requester exclusion
module rr_pick2 (
  input  logic       valid_0,
  input  logic       valid_1,
  input  logic       last_owner,
  input  logic [1:0] exclude,
  output logic       win_valid,
  output logic       win_id
);

  logic v0;
  logic v1;

  assign v0        = valid_0 && !exclude[0];
  assign v1        = valid_1 && !exclude[1];
  assign win_valid = v0 || v1;
  // On a tie the CPU that did not own the bus last wins.
  assign win_id    = (v0 && v1) ? !last_owner : v1;

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-CPU round-robin bus arbiter and transaction sequencer
module bus_arbiter
  import common::*;
#(
  parameter int DMEM_LAT = 4,
  parameter int FWD_LAT  = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    req_0,
  input  logic    req_1,
  input  bus_op_t op_0,
  input  bus_op_t op_1,
  input  logic    snoop_hit,
  output logic    grant_0,
  output logic    grant_1,
  output bus_op_t bus_op,
  output logic    bus_start,
  output logic    ack_0,
  output logic    ack_1,
  output logic    last_owner
);

  localparam logic [3:0] DMEM_LOAD = 4'(DMEM_LAT - 1);
  // The snoop reload happens after one grant cycle has already elapsed.
  localparam logic [3:0] FWD_LOAD  = (FWD_LAT >= 2) ? 4'(FWD_LAT - 2) : 4'd0;

  arb_state_t  state_q;
  logic        owner_q;
  bus_arb_op_t op_q;
  logic [3:0]  cnt_q;
  logic        first_q;
  logic        last_owner_q;

  bus_arb_op_t op0_n;
  bus_arb_op_t op1_n;
  bus_arb_op_t win_op;
  logic        valid_0;
  logic        valid_1;
  logic [1:0]  exclude;
  logic        win_valid;
  logic        win_id;
  logic        owner_req;
  logic        snoop_fwd;
  logic        last_cyc;
  logic        start;

  function automatic logic [3:0] load_for(input bus_arb_op_t op);
    return (op == OP_INV) ? 4'd0 : DMEM_LOAD;
  endfunction

  assign op0_n     = op_decode(op_0);
  assign op1_n     = op_decode(op_1);
  assign valid_0   = req_0 && (op0_n != OP_NONE);
  assign valid_1   = req_1 && (op1_n != OP_NONE);
  assign exclude   = (state_q == ST_BUSY) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign win_op    = win_id ? op1_n : op0_n;
  assign owner_req = owner_q ? req_1 : req_0;

  assign snoop_fwd = first_q && (op_q == OP_RD_MISS) && snoop_hit;
  // A one-cycle forward makes the first grant cycle the last, so ack must see snoop_hit directly.
  assign last_cyc  = (state_q == ST_BUSY) &&
                     ((cnt_q == 4'd0) || ((FWD_LAT == 1) && snoop_fwd));
  assign start     = win_valid && ((state_q == ST_IDLE) || last_cyc);

  rr_pick2 u_pick (
    .valid_0    (valid_0),
    .valid_1    (valid_1),
    .last_owner (last_owner_q),
    .exclude    (exclude),
    .win_valid  (win_valid),
    .win_id     (win_id)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      op_q         <= OP_NONE;
      cnt_q        <= 4'd0;
      first_q      <= 1'b0;
      last_owner_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (start) begin
        state_q      <= ST_BUSY;
        owner_q      <= win_id;
        op_q         <= win_op;
        cnt_q        <= load_for(win_op);
        first_q      <= 1'b1;
        last_owner_q <= win_id;
      end else if (state_q == ST_BUSY) begin
        if (last_cyc || !owner_req) begin
          state_q <= ST_IDLE;
        end else if (snoop_fwd) begin
          cnt_q <= FWD_LOAD;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

  assign grant_0    = (state_q == ST_BUSY) && !owner_q;
  assign grant_1    = (state_q == ST_BUSY) && owner_q;
  assign bus_op     = (state_q == ST_BUSY) ? bus_op_t'(op_q) : bus_op_t'(OP_NONE);
  assign bus_start  = first_q;
  assign ack_0      = last_cyc && !owner_q;
  assign ack_1      = last_cyc && owner_q;
  assign last_owner = last_owner_q;

endmodule
